// File: rtl/fu_pkg.sv
// Shared encodings for the pipelined functional unit: unit selects,
// ALU sub-opcodes, flag bit positions and opcode legality.
package fu_pkg;

    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_SHIFT = 2'd1,
        FU_MADD  = 2'd2,
        FU_BAD   = 2'd3
    } fu_unit_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_PASS = 4'd6,
        OP_SLT  = 4'd7
    } fu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic alu_op_legal(input logic [3:0] op);
        return (op <= 4'(OP_SLT));
    endfunction

endpackage

// File: rtl/fu_madd_pipe.sv
// Unsigned multiply-add, (a*b + c) mod 2^WIDTH, spread over MADD_STAGES
// registers that advance only while en_i is high.
module fu_madd_pipe #(
    parameter int WIDTH       = 32,
    parameter int MADD_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] z_o
);

    logic [WIDTH-1:0] prod_d;
    logic [WIDTH-1:0] prod_p1_q;
    logic [WIDTH-1:0] addend_p1_q;

    assign prod_d = a_i * b_i;

    // stage 1: truncated product with its addend
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            prod_p1_q   <= prod_d;
            addend_p1_q <= c_i;
        end
    end

    if (MADD_STAGES == 1) begin : g_single
        assign z_o = prod_p1_q + addend_p1_q;
    end else begin : g_multi
        logic [WIDTH-1:0] sum_q [MADD_STAGES-1];

        // stage 2: accumulate; later stages only delay the sum
        always_ff @(posedge clk_i) begin
            if (en_i) begin
                sum_q[0] <= prod_p1_q + addend_p1_q;
                for (int s = 1; s < MADD_STAGES - 1; s++) begin
                    sum_q[s] <= sum_q[s-1];
                end
            end
        end

        assign z_o = sum_q[MADD_STAGES-2];
    end

endmodule

// File: rtl/functional_unit_pipe.sv
// ALU, barrel shifter and multiply-add behind one valid/ready issue port;
// every operation takes MADD_STAGES+1 cycles so results retire in order.
module functional_unit_pipe
    import fu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MADD_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       UNIT,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             CI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       FLAGS,
    output logic             OUT_ERR
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = MADD_STAGES - 1;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] z,
                                              input logic c, input logic v,
                                              input logic err);
        logic [3:0] f;
        f = '0;
        if (!err) begin
            f[FLAG_N] = z[WIDTH-1];
            f[FLAG_Z] = (z == '0);
            f[FLAG_C] = c;
            f[FLAG_V] = v;
        end
        return f;
    endfunction

    logic en;
    logic out_valid_q;

    assign en       = !out_valid_q || OUT_READY;
    assign IN_READY = en;

    // Arithmetic helpers for stage 1
    logic        [WIDTH:0]   add_w;
    logic        [WIDTH:0]   sub_w;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sra_w;
    logic        [SHAMT_W-1:0] shamt;
    logic                    sh_left;
    logic                    sh_logical;

    assign add_w      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CI};
    assign sub_w      = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign a_s        = A;
    assign b_s        = B;
    assign shamt      = B[SHAMT_W-1:0];
    assign sh_left    = B[SHAMT_W];
    assign sh_logical = B[SHAMT_W+1];
    assign sra_w      = a_s >>> shamt;

    logic [WIDTH-1:0] side_z_d;
    logic             side_c_d;
    logic             side_v_d;
    logic             err_d;
    logic             is_madd_d;

    always_comb begin
        side_z_d  = '0;
        side_c_d  = 1'b0;
        side_v_d  = 1'b0;
        err_d     = 1'b0;
        is_madd_d = 1'b0;
        case (fu_unit_e'(UNIT))
            FU_ALU: begin
                if (!alu_op_legal(OP)) begin
                    err_d = 1'b1;
                end else begin
                    case (fu_op_e'(OP))
                        OP_ADD: begin
                            side_z_d = add_w[WIDTH-1:0];
                            side_c_d = add_w[WIDTH];
                            side_v_d = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_SUB: begin
                            side_z_d = sub_w[WIDTH-1:0];
                            side_c_d = sub_w[WIDTH];
                            side_v_d = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_AND:  side_z_d = A & B;
                        OP_OR:   side_z_d = A | B;
                        OP_XOR:  side_z_d = A ^ B;
                        OP_NOT:  side_z_d = ~A;
                        OP_PASS: side_z_d = A;
                        OP_SLT:  side_z_d[0] = (a_s < b_s);
                        default: err_d = 1'b1;
                    endcase
                end
            end
            FU_SHIFT: begin
                if (sh_left) begin
                    side_z_d = A << shamt;
                end else if (sh_logical) begin
                    side_z_d = A >> shamt;
                end else begin
                    side_z_d = sra_w;
                end
            end
            FU_MADD: is_madd_d = 1'b1;
            default: err_d = 1'b1;
        endcase
    end

    logic [WIDTH-1:0] madd_z;

    fu_madd_pipe #(
        .WIDTH       (WIDTH),
        .MADD_STAGES (MADD_STAGES)
    ) u_madd (
        .clk_i (CLOCK),
        .en_i  (en),
        .a_i   (A),
        .b_i   (B),
        .c_i   (C),
        .z_o   (madd_z)
    );

    logic             vld_q     [MADD_STAGES];
    logic [WIDTH-1:0] side_z_q  [MADD_STAGES];
    logic             side_c_q  [MADD_STAGES];
    logic             side_v_q  [MADD_STAGES];
    logic             err_q     [MADD_STAGES];
    logic             is_madd_q [MADD_STAGES];

    // stages 1..MADD_STAGES: ALU/shifter results ride alongside the MADD pipe
    always_ff @(posedge CLOCK) begin
        if (en) begin
            side_z_q[0]  <= side_z_d;
            side_c_q[0]  <= side_c_d;
            side_v_q[0]  <= side_v_d;
            err_q[0]     <= err_d;
            is_madd_q[0] <= is_madd_d;
            for (int s = 1; s < MADD_STAGES; s++) begin
                side_z_q[s]  <= side_z_q[s-1];
                side_c_q[s]  <= side_c_q[s-1];
                side_v_q[s]  <= side_v_q[s-1];
                err_q[s]     <= err_q[s-1];
                is_madd_q[s] <= is_madd_q[s-1];
            end
        end
    end

    logic [WIDTH-1:0] res_z_d;
    logic [3:0]       res_flags_d;

    assign res_z_d     = is_madd_q[LAST] ? madd_z : side_z_q[LAST];
    assign res_flags_d = make_flags(res_z_d, side_c_q[LAST], side_v_q[LAST], err_q[LAST]);

    logic [WIDTH-1:0] z_q;
    logic [3:0]       flags_q;
    logic             out_err_q;

    // output register: data only changes when a real result lands
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int s = 0; s < MADD_STAGES; s++) begin
                vld_q[s] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            out_err_q   <= 1'b0;
        end else if (en) begin
            vld_q[0] <= IN_VALID;
            for (int s = 1; s < MADD_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
            out_valid_q <= vld_q[LAST];
            if (vld_q[LAST]) begin
                z_q       <= res_z_d;
                flags_q   <= res_flags_d;
                out_err_q <= err_q[LAST];
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign Z         = z_q;
    assign FLAGS     = flags_q;
    assign OUT_ERR   = out_err_q;

endmodule

// File: doc/functional_unit_pipe.md
Name: functional_unit_pipe

Overview:
- Parametrised, pipelined successor of the Mosaic functional unit.
- Hosts three execution units behind one valid/ready issue port and one valid/ready result port: ALU, barrel shifter and multiply-add (MADD).
- Per-unit clock gating is replaced by pipeline enables.
- All operations share one fixed latency, so results retire strictly in issue order, one per cycle, with full backpressure.

Parameters:
- WIDTH, 32: datapath width of A, B, C and Z; must be at least 8.
- MADD_STAGES, 2: register stages inside the multiply-add; must be at least 1.
- SHAMT_W, $clog2(WIDTH): derived localparam giving the shift-amount width. It is not overridable.

Ports:
- CLOCK, input, 1: sole clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- IN_VALID, input, 1: operation presented.
- IN_READY, output, 1: operation accepted when IN_VALID && IN_READY at the CLOCK edge.
- UNIT, input, 2: unit select. 0 = ALU, 1 = shifter, 2 = MADD, 3 = illegal.
- OP, input, 4: ALU sub-opcode; ignored by the other units.
- A, B, C, input, WIDTH each: operands.
- CI, input, 1: carry-in for ALU ADD.
- OUT_VALID, output, 1: result register holds a result.
- OUT_READY, input, 1: consumer takes the result.
- Z, output, WIDTH: result.
- FLAGS, output, 4: {N, Zf, C, V}.
- OUT_ERR, output, 1: result came from an illegal UNIT or OP.

Behaviour:
- Clock and reset: one clock, CLOCK; RESET is asynchronous and active-high.
- Reset values: all stage valid bits 0, OUT_VALID 0, Z 0, FLAGS 0, OUT_ERR 0. Any operation in flight is discarded.
- Latency: L = MADD_STAGES + 1 cycles from the accept edge to OUT_VALID, for every UNIT.
- ALU and shifter results are computed in stage 1. They travel with their valid bit alongside the MADD stages, so no reordering is possible.
- Pipeline enable: EN = !OUT_VALID || OUT_READY. IN_READY = EN.
- When EN is 0, every stage, including the output register, holds its contents.
- When EN is 1, every stage advances. The output register loads the last stage and OUT_VALID takes that stage's valid bit.
- Bubbles propagate as valid = 0. Throughput is one operation per cycle when OUT_READY is held at 1.
- Simultaneous accept and retire in the same cycle is legal and required.
- ALU OP codes:
  - 0 ADD: A + B + CI. C = carry-out; V = signed overflow.
  - 1 SUB: A - B. C = 1 when no borrow; V = signed overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT A, 6 PASS A.
  - 7 SLT: 1 if A < B signed, else 0.
  - 8..15 illegal: Z = 0, OUT_ERR = 1.
  - For every opcode other than ADD and SUB, C and V are 0.
- Shifter:
  - Shift amount is B[SHAMT_W-1:0].
  - B[SHAMT_W] = 1 shifts left, 0 shifts right.
  - B[SHAMT_W+1] = 1 selects a logical shift, 0 an arithmetic shift. It applies to right shifts only; a left shift is always logical.
  - A shift amount of 0 returns A. C and V are 0.
- MADD: Z = (A * B + C) mod 2^WIDTH, unsigned. C and V are 0.
- UNIT 3: the operation is accepted and occupies a slot. It returns Z = 0, FLAGS = 0, OUT_ERR = 1.
- N = Z[WIDTH-1] and Zf = (Z == 0) for all legal operations.
- Inputs are sampled only at an accept edge. Operand changes while IN_READY is 0 have no effect.
- If RESET is asserted during backpressure, the held result is dropped. The block accepts new operations on the first edge after RESET deasserts.

Decomposition:
- Package fu_pkg holds:
  - UNIT encodings (FU_ALU, FU_SHIFT, FU_MADD).
  - ALU opcode constants (OP_ADD … OP_SLT).
  - Flag bit indices (FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0).
- One sub-module, fu_madd_pipe: WIDTH and MADD_STAGES parameters, EN input, and a pipelined multiply-add with MADD_STAGES registers.
- The ALU, shifter and flag logic stay inline in functional_unit_pipe.

Test Plan (WIDTH = 32, MADD_STAGES = 2, so L = 3):
- Reset then a single ADD with A = 0xFFFFFFFF, B = 1, CI = 0 -> 3 cycles later OUT_VALID = 1, Z = 0, FLAGS = 4'b0110, OUT_ERR = 0.
- SUB with A = 0x80000000, B = 1 -> Z = 0x7FFFFFFF, FLAGS = 4'b0011 (C = 1 no borrow, V = 1).
- Shifter with A = 0x80000000, B = 0x04 (right, arithmetic, amount 4) -> Z = 0xF8000000. With B = 0x44 (logical) -> Z = 0x08000000. With B = 0x21 (left by 1) -> Z = 0.
- Back-to-back MADD (A = 3, B = 5, C = 7), then ALU PASS A = 9, then UNIT = 3, with OUT_READY = 1 -> on consecutive cycles Z = 22, then 9, then 0 with OUT_ERR = 1. No gaps and no reordering.
- Hold OUT_READY = 0 for 5 cycles during a 6-operation stream -> Z is stable and IN_READY = 0 while the output is held. After release, all 6 results arrive in order and none are lost or duplicated.
- Assert RESET for one cycle with 3 operations in flight and the output held -> OUT_VALID drops to 0 asynchronously. No stale result appears afterwards, and a new ADD (2 + 2) returns 4 after 3 cycles.
